nasti_mem_slave: RTL and testbench

Synthesizable AXI4 (Nasti) slave memory that responds to the FPGA-side master port of the NastiShim (64-bit data, 6-bit IDs, INCR bursts). It stands in for the Zynq HP/DDR slave port on board bring-up builds and in simulation, so the shim's memory traffic can run without the PS. It contains independent read and write state machines in front of a byte-writable on-chip memory.

---
 rtl/nasti_mem_slave.sv | 181 ++++++++++++++++++
 tb/tb_nasti_mem_slave.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nasti_mem_slave.sv
// AXI4 (Nasti) slave backed by a byte-writable on-chip memory, standing in for the
// Zynq HP/DDR port. Independent read and write FSMs, one outstanding burst each.
module nasti_mem_slave #(
  parameter int DATA_W   = 64,
  parameter int ID_W     = 6,
  parameter int ADDR_W   = 32,
  parameter int MEM_LOG2 = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_ar_valid,
  output logic              io_ar_ready,
  input  logic [ADDR_W-1:0] io_ar_bits_addr,
  input  logic [ID_W-1:0]   io_ar_bits_id,
  input  logic [7:0]        io_ar_bits_len,
  input  logic [2:0]        io_ar_bits_size,
  input  logic              io_aw_valid,
  output logic              io_aw_ready,
  input  logic [ADDR_W-1:0] io_aw_bits_addr,
  input  logic [ID_W-1:0]   io_aw_bits_id,
  input  logic [7:0]        io_aw_bits_len,
  input  logic [2:0]        io_aw_bits_size,
  input  logic              io_w_valid,
  output logic              io_w_ready,
  input  logic [DATA_W-1:0] io_w_bits_data,
  input  logic [DATA_W/8-1:0] io_w_bits_strb,
  input  logic              io_w_bits_last,
  output logic              io_b_valid,
  input  logic              io_b_ready,
  output logic [ID_W-1:0]   io_b_bits_id,
  output logic [1:0]        io_b_bits_resp,
  output logic              io_r_valid,
  input  logic              io_r_ready,
  output logic [DATA_W-1:0] io_r_bits_data,
  output logic [ID_W-1:0]   io_r_bits_id,
  output logic              io_r_bits_last,
  output logic [1:0]        io_r_bits_resp
);

  localparam int DEPTH  = 1 << MEM_LOG2;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rdState_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wrState_e;

  rdState_e rdState_q, rdState_d;
  wrState_e wrState_q, wrState_d;
  logic [1:0] live_q;

  logic [MEM_LOG2-1:0] rdIdx_q;
  logic [ID_W-1:0]     rdId_q;
  logic [7:0]          rdLen_q, rdCnt_q;
  logic                rdErr_q;

  logic [MEM_LOG2-1:0] wrIdx_q;
  logic [ID_W-1:0]     wrId_q;
  logic [7:0]          wrLen_q;
  logic [8:0]          wrCnt_q;
  logic                wrSizeErr_q, wrBad_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] memRd_q;

  logic arFire, rFire, awFire, wFire, bFire;
  logic rdLastBeat, wrInRange, wrCommit;

  logic unusedBits;
  assign unusedBits = ^{io_ar_bits_addr[ADDR_W-1:MEM_LOG2+3], io_ar_bits_addr[2:0],
                        io_aw_bits_addr[ADDR_W-1:MEM_LOG2+3], io_aw_bits_addr[2:0]};

  assign arFire     = io_ar_valid && io_ar_ready;
  assign rFire      = io_r_valid && io_r_ready;
  assign awFire     = io_aw_valid && io_aw_ready;
  assign wFire      = io_w_valid && io_w_ready;
  assign bFire      = io_b_valid && io_b_ready;
  assign rdLastBeat = (rdCnt_q == rdLen_q);
  assign wrInRange  = (wrCnt_q <= {1'b0, wrLen_q});
  assign wrCommit   = wFire && wrInRange && !wrSizeErr_q;

  // live_q delays ready until the second edge after reset so the master sees a quiet first cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdState_q <= R_IDLE;
      wrState_q <= W_IDLE;
      live_q    <= 2'b00;
    end else begin
      rdState_q <= rdState_d;
      wrState_q <= wrState_d;
      live_q    <= {live_q[0], 1'b1};
    end
  end

  always_comb begin
    rdState_d = rdState_q;
    case (rdState_q)
      R_IDLE:  if (arFire) rdState_d = R_FETCH;
      R_FETCH: rdState_d = R_DATA;
      R_DATA:  if (rFire) rdState_d = rdLastBeat ? R_IDLE : R_FETCH;
      default: rdState_d = R_IDLE;
    endcase
  end

  always_comb begin
    wrState_d = wrState_q;
    case (wrState_q)
      W_IDLE:  if (awFire) wrState_d = W_DATA;
      W_DATA:  if (wFire && io_w_bits_last) wrState_d = W_RESP;
      W_RESP:  if (bFire) wrState_d = W_IDLE;
      default: wrState_d = W_IDLE;
    endcase
  end

  // Payloads are forced to zero whenever the matching valid is low
  always_comb begin
    io_ar_ready    = (rdState_q == R_IDLE) && live_q[1];
    io_r_valid     = (rdState_q == R_DATA);
    io_r_bits_data = (io_r_valid && !rdErr_q) ? memRd_q : '0;
    io_r_bits_id   = io_r_valid ? rdId_q : '0;
    io_r_bits_last = io_r_valid && rdLastBeat;
    io_r_bits_resp = (io_r_valid && rdErr_q) ? 2'b10 : 2'b00;
    io_aw_ready    = (wrState_q == W_IDLE) && live_q[1];
    io_w_ready     = (wrState_q == W_DATA);
    io_b_valid     = (wrState_q == W_RESP);
    io_b_bits_id   = io_b_valid ? wrId_q : '0;
    io_b_bits_resp = (io_b_valid && wrBad_q) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdIdx_q <= '0;
      rdId_q  <= '0;
      rdLen_q <= '0;
      rdCnt_q <= '0;
      rdErr_q <= 1'b0;
    end else if (arFire) begin
      rdIdx_q <= io_ar_bits_addr[MEM_LOG2+2:3];
      rdId_q  <= io_ar_bits_id;
      rdLen_q <= io_ar_bits_len;
      rdCnt_q <= '0;
      rdErr_q <= (io_ar_bits_size != 3'd3);
    end else if (rFire && !rdLastBeat) begin
      rdIdx_q <= rdIdx_q + MEM_LOG2'(1);
      rdCnt_q <= rdCnt_q + 8'd1;
    end
  end

  // Beats past len are swallowed; the 9-bit count saturates so an overrun stays flagged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrIdx_q     <= '0;
      wrId_q      <= '0;
      wrLen_q     <= '0;
      wrCnt_q     <= '0;
      wrSizeErr_q <= 1'b0;
      wrBad_q     <= 1'b0;
    end else if (awFire) begin
      wrIdx_q     <= io_aw_bits_addr[MEM_LOG2+2:3];
      wrId_q      <= io_aw_bits_id;
      wrLen_q     <= io_aw_bits_len;
      wrCnt_q     <= '0;
      wrSizeErr_q <= (io_aw_bits_size != 3'd3);
      wrBad_q     <= (io_aw_bits_size != 3'd3);
    end else if (wFire) begin
      wrIdx_q <= wrIdx_q + MEM_LOG2'(1);
      wrCnt_q <= (wrCnt_q == 9'h1FF) ? wrCnt_q : wrCnt_q + 9'd1;
      wrBad_q <= wrBad_q || !wrInRange ||
                 (io_w_bits_last && (wrCnt_q != {1'b0, wrLen_q}));
    end
  end

  // Read-before-write: a fetch colliding with a write to the same word sees old data
  always_ff @(posedge clk) begin
    if (wrCommit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (io_w_bits_strb[b]) mem[wrIdx_q][8*b +: 8] <= io_w_bits_data[8*b +: 8];
      end
    end
    if (rdState_q == R_FETCH) memRd_q <= mem[rdIdx_q];
  end

endmodule

// File: tb/tb_nasti_mem_slave.sv
// Directed bench for nasti_mem_slave: single beats, wrapping bursts, strobes,
// error responses, backpressure with concurrent bursts and reset mid-read.
module tb_nasti_mem_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_ar_valid = 1'b0, io_ar_ready;
  logic [31:0] io_ar_bits_addr = '0;
  logic [5:0]  io_ar_bits_id = '0;
  logic [7:0]  io_ar_bits_len = '0;
  logic [2:0]  io_ar_bits_size = '0;
  logic        io_aw_valid = 1'b0, io_aw_ready;
  logic [31:0] io_aw_bits_addr = '0;
  logic [5:0]  io_aw_bits_id = '0;
  logic [7:0]  io_aw_bits_len = '0;
  logic [2:0]  io_aw_bits_size = '0;
  logic        io_w_valid = 1'b0, io_w_ready;
  logic [63:0] io_w_bits_data = '0;
  logic [7:0]  io_w_bits_strb = '0;
  logic        io_w_bits_last = 1'b0;
  logic        io_b_valid, io_b_ready = 1'b0;
  logic [5:0]  io_b_bits_id;
  logic [1:0]  io_b_bits_resp;
  logic        io_r_valid, io_r_ready = 1'b0;
  logic [63:0] io_r_bits_data;
  logic [5:0]  io_r_bits_id;
  logic        io_r_bits_last;
  logic [1:0]  io_r_bits_resp;

  int checkCount = 0;
  int failCount = 0;
  logic [63:0] expRdQ[$];
  logic [63:0] wDataQ[$];
  logic [7:0]  wStrbQ[$];

  nasti_mem_slave dut (
    .clk(clk), .reset(reset),
    .io_ar_valid(io_ar_valid), .io_ar_ready(io_ar_ready),
    .io_ar_bits_addr(io_ar_bits_addr), .io_ar_bits_id(io_ar_bits_id),
    .io_ar_bits_len(io_ar_bits_len), .io_ar_bits_size(io_ar_bits_size),
    .io_aw_valid(io_aw_valid), .io_aw_ready(io_aw_ready),
    .io_aw_bits_addr(io_aw_bits_addr), .io_aw_bits_id(io_aw_bits_id),
    .io_aw_bits_len(io_aw_bits_len), .io_aw_bits_size(io_aw_bits_size),
    .io_w_valid(io_w_valid), .io_w_ready(io_w_ready),
    .io_w_bits_data(io_w_bits_data), .io_w_bits_strb(io_w_bits_strb),
    .io_w_bits_last(io_w_bits_last),
    .io_b_valid(io_b_valid), .io_b_ready(io_b_ready),
    .io_b_bits_id(io_b_bits_id), .io_b_bits_resp(io_b_bits_resp),
    .io_r_valid(io_r_valid), .io_r_ready(io_r_ready),
    .io_r_bits_data(io_r_bits_data), .io_r_bits_id(io_r_bits_id),
    .io_r_bits_last(io_r_bits_last), .io_r_bits_resp(io_r_bits_resp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Each beat's expected data is popped from expRdQ
  task automatic rdBurst(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] expResp, input bit randomReady);
    int n;
    int hold;
    logic [63:0] expData;
    io_ar_bits_addr = addr;
    io_ar_bits_id   = id;
    io_ar_bits_len  = len;
    io_ar_bits_size = size;
    io_ar_valid     = 1'b1;
    n = 0;
    while (!io_ar_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!io_ar_ready) checkOutput("ar_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    io_ar_valid = 1'b0;
    checkOutput("r_lat_fetch", 64'(io_r_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("r_lat_valid", 64'(io_r_valid), 64'd1);
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!io_r_valid && n < 50) begin @(posedge clk); #1; n++; end
      if (!io_r_valid) checkOutput("r_timeout", 64'd0, 64'd1);
      expData = expRdQ.pop_front();
      hold = randomReady ? int'($urandom_range(0, 3)) : 0;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checkOutput("r_hold_valid", 64'(io_r_valid), 64'd1);
        checkOutput("r_hold_data", io_r_bits_data, expData);
        checkOutput("r_hold_last", 64'(io_r_bits_last), 64'(b == int'(len)));
      end
      checkOutput("r_data", io_r_bits_data, expData);
      checkOutput("r_id", 64'(io_r_bits_id), 64'(id));
      checkOutput("r_last", 64'(io_r_bits_last), 64'(b == int'(len)));
      checkOutput("r_resp", 64'(io_r_bits_resp), 64'(expResp));
      io_r_ready = 1'b1;
      @(posedge clk); #1;
      io_r_ready = 1'b0;
      checkOutput("r_gap", 64'(io_r_valid), 64'd0);
    end
  endtask

  // Sends lastBeat+1 beats from wDataQ/wStrbQ, w_last on the final one
  task automatic wrBurst(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len,
                         input logic [2:0] size, input int lastBeat, input logic [1:0] expResp,
                         input bit randomB);
    int n;
    int hold;
    io_aw_bits_addr = addr;
    io_aw_bits_id   = id;
    io_aw_bits_len  = len;
    io_aw_bits_size = size;
    io_aw_valid     = 1'b1;
    n = 0;
    while (!io_aw_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!io_aw_ready) checkOutput("aw_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    io_aw_valid = 1'b0;
    checkOutput("w_ready_first", 64'(io_w_ready), 64'd1);
    for (int i = 0; i <= lastBeat; i++) begin
      io_w_bits_data = wDataQ.pop_front();
      io_w_bits_strb = wStrbQ.pop_front();
      io_w_bits_last = (i == lastBeat);
      io_w_valid     = 1'b1;
      n = 0;
      while (!io_w_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!io_w_ready) checkOutput("w_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
    io_w_valid     = 1'b0;
    io_w_bits_last = 1'b0;
    checkOutput("b_lat", 64'(io_b_valid), 64'd1);
    hold = randomB ? int'($urandom_range(0, 3)) : 0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("b_hold_valid", 64'(io_b_valid), 64'd1);
      checkOutput("b_hold_resp", 64'(io_b_bits_resp), 64'(expResp));
    end
    checkOutput("b_id", 64'(io_b_bits_id), 64'(id));
    checkOutput("b_resp", 64'(io_b_bits_resp), 64'(expResp));
    io_b_ready = 1'b1;
    @(posedge clk); #1;
    io_b_ready = 1'b0;
    checkOutput("b_drop", 64'(io_b_valid), 64'd0);
  endtask

  task automatic pushWrite(input logic [63:0] data, input logic [7:0] strb);
    wDataQ.push_back(data);
    wStrbQ.push_back(strb);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ar_ready", 64'(io_ar_ready), 64'd0);
    checkOutput("rst_aw_ready", 64'(io_aw_ready), 64'd0);
    checkOutput("rst_w_ready", 64'(io_w_ready), 64'd0);
    checkOutput("rst_r_valid", 64'(io_r_valid), 64'd0);
    checkOutput("rst_b_valid", 64'(io_b_valid), 64'd0);
    checkOutput("rst_r_data", io_r_bits_data, 64'd0);
    checkOutput("rst_b_id", 64'(io_b_bits_id), 64'd0);
    reset = 1'b0;
    checkOutput("rel_ar_ready0", 64'(io_ar_ready), 64'd0);
    @(posedge clk); #1;
    checkOutput("rel_ar_ready1", 64'(io_ar_ready), 64'd0);
    checkOutput("rel_aw_ready1", 64'(io_aw_ready), 64'd0);
    @(posedge clk); #1;
    checkOutput("rel_ar_ready2", 64'(io_ar_ready), 64'd1);
    checkOutput("rel_aw_ready2", 64'(io_aw_ready), 64'd1);

    pushWrite(64'h0123_4567_89AB_CDEF, 8'hFF);
    wrBurst(32'h10, 6'd5, 8'd0, 3'd3, 0, 2'b00, 1'b0);
    expRdQ.push_back(64'h0123_4567_89AB_CDEF);
    rdBurst(32'h10, 6'd5, 8'd0, 3'd3, 2'b00, 1'b0);

    // Index 1022 wraps through 1023 to 0 and 1; high and low address bits alias
    for (int i = 1; i <= 4; i++) pushWrite(64'(i), 8'hFF);
    wrBurst(32'h1FF0, 6'd1, 8'd3, 3'd3, 3, 2'b00, 1'b0);
    for (int i = 1; i <= 4; i++) expRdQ.push_back(64'(i));
    rdBurst(32'h1FF0, 6'd2, 8'd3, 3'd3, 2'b00, 1'b0);
    expRdQ.push_back(64'd3); expRdQ.push_back(64'd4);
    rdBurst(32'h0, 6'd3, 8'd1, 3'd3, 2'b00, 1'b0);
    expRdQ.push_back(64'd3);
    rdBurst(32'h8000_2005, 6'd4, 8'd0, 3'd3, 2'b00, 1'b0);

    pushWrite(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wrBurst(32'h100, 6'd7, 8'd0, 3'd3, 0, 2'b00, 1'b0);
    pushWrite(64'h0, 8'h0F);
    wrBurst(32'h100, 6'd7, 8'd0, 3'd3, 0, 2'b00, 1'b0);
    expRdQ.push_back(64'hFFFF_FFFF_0000_0000);
    rdBurst(32'h100, 6'd8, 8'd0, 3'd3, 2'b00, 1'b0);
    pushWrite(64'h1122_3344_5566_7788, 8'h81);
    wrBurst(32'h100, 6'd7, 8'd0, 3'd3, 0, 2'b00, 1'b0);
    expRdQ.push_back(64'h11FF_FFFF_0000_0088);
    rdBurst(32'h100, 6'd8, 8'd0, 3'd3, 2'b00, 1'b0);

    expRdQ.push_back(64'd0); expRdQ.push_back(64'd0);
    rdBurst(32'h10, 6'd9, 8'd1, 3'd2, 2'b10, 1'b0);

    // Early w_last: only the two beats sent land, the tail keeps its preset
    for (int i = 0; i < 4; i++) pushWrite(64'hCCCC_CCCC_CCCC_CCCC, 8'hFF);
    wrBurst(32'h200, 6'd10, 8'd3, 3'd3, 3, 2'b00, 1'b0);
    pushWrite(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    pushWrite(64'hBBBB_BBBB_BBBB_BBBB, 8'hFF);
    wrBurst(32'h200, 6'd10, 8'd3, 3'd3, 1, 2'b10, 1'b0);
    expRdQ.push_back(64'hAAAA_AAAA_AAAA_AAAA);
    expRdQ.push_back(64'hBBBB_BBBB_BBBB_BBBB);
    expRdQ.push_back(64'hCCCC_CCCC_CCCC_CCCC);
    expRdQ.push_back(64'hCCCC_CCCC_CCCC_CCCC);
    rdBurst(32'h200, 6'd11, 8'd3, 3'd3, 2'b00, 1'b0);

    // Overrun beat is dropped, and a size-2 write commits nothing
    pushWrite(64'hEEEE, 8'hFF); pushWrite(64'hEEEE, 8'hFF);
    wrBurst(32'h300, 6'd12, 8'd1, 3'd3, 1, 2'b00, 1'b0);
    pushWrite(64'hD1, 8'hFF); pushWrite(64'hD2, 8'hFF);
    wrBurst(32'h300, 6'd12, 8'd0, 3'd3, 1, 2'b10, 1'b0);
    pushWrite(64'hFF, 8'hFF);
    wrBurst(32'h300, 6'd13, 8'd0, 3'd2, 0, 2'b10, 1'b0);
    expRdQ.push_back(64'hD1); expRdQ.push_back(64'hEEEE);
    rdBurst(32'h300, 6'd14, 8'd1, 3'd3, 2'b00, 1'b0);

    for (int i = 0; i < 16; i++) pushWrite(64'hA5A5_0000_0000_0000 | 64'(i), 8'hFF);
    wrBurst(32'h400, 6'd15, 8'd15, 3'd3, 15, 2'b00, 1'b0);
    for (int i = 0; i < 16; i++) pushWrite(64'h5A5A_0000_0000_1000 + 64'(i * 3), 8'hFF);
    for (int i = 0; i < 16; i++) expRdQ.push_back(64'hA5A5_0000_0000_0000 | 64'(i));
    fork
      wrBurst(32'h800, 6'd20, 8'd15, 3'd3, 15, 2'b00, 1'b1);
      rdBurst(32'h400, 6'd21, 8'd15, 3'd3, 2'b00, 1'b1);
    join
    for (int i = 0; i < 16; i++) expRdQ.push_back(64'h5A5A_0000_0000_1000 + 64'(i * 3));
    rdBurst(32'h800, 6'd22, 8'd15, 3'd3, 2'b00, 1'b1);

    for (int i = 0; i < 8; i++) pushWrite(64'h600 + 64'(i), 8'hFF);
    wrBurst(32'hC00, 6'd30, 8'd7, 3'd3, 7, 2'b00, 1'b0);
    io_ar_bits_addr = 32'hC00;
    io_ar_bits_id   = 6'd30;
    io_ar_bits_len  = 8'd7;
    io_ar_bits_size = 3'd3;
    io_ar_valid     = 1'b1;
    @(posedge clk); #1;
    io_ar_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      n = 0;
      while (!io_r_valid && n < 50) begin @(posedge clk); #1; n++; end
      checkOutput("mid_data", io_r_bits_data, 64'h600 + 64'(b));
      io_r_ready = 1'b1;
      @(posedge clk); #1;
      io_r_ready = 1'b0;
    end
    n = 0;
    while (!io_r_valid && n < 50) begin @(posedge clk); #1; n++; end
    checkOutput("mid_beat3_valid", 64'(io_r_valid), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_r_valid", 64'(io_r_valid), 64'd0);
    checkOutput("mid_rst_ar_ready", 64'(io_ar_ready), 64'd0);
    checkOutput("mid_rst_r_data", io_r_bits_data, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("mid_rel_ar0", 64'(io_ar_ready), 64'd0);
    @(posedge clk); #1;
    checkOutput("mid_rel_ar1", 64'(io_ar_ready), 64'd0);
    @(posedge clk); #1;
    checkOutput("mid_rel_ar2", 64'(io_ar_ready), 64'd1);
    for (int i = 0; i < 8; i++) expRdQ.push_back(64'h600 + 64'(i));
    rdBurst(32'hC00, 6'd31, 8'd7, 3'd3, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
